booth_div: RTL

- Sequential signed divider that complements the team's Booth-style shift/add multiplier datapath.
- Accepts a two's-complement dividend and divisor on a start pulse and computes them by restoring division on magnitudes, one quotient bit per clock.
- Applies a sign fix-up and presents quotient and remainder with a done pulse.
- Sits beside the multiplier in the arithmetic unit; the controller drives it with the same busy-based handshake.

---
 rtl/booth_div.sv | 132 +++++++++++++
 1 files changed

// File: rtl/booth_div.sv
// Sequential signed divider: restoring division on operand magnitudes, one
// quotient bit per clock, then a sign fix-up and a one-cycle done pulse.
//
// Handshake: start is sampled only in IDLE. Once it is accepted, busy stays
// high through CALC and FIX. done is high for exactly one cycle in DONE. In
// any other state start is ignored and the operands are not re-sampled.
module booth_div #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow,
    output logic [1:0]       state_dbg
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state;
    logic [WIDTH:0]   a;
    logic [WIDTH-1:0] q;
    logic [WIDTH:0]   m;
    logic [CW-1:0]    count;
    logic             qneg;
    logic             rneg;
    logic             ovf_case;

    logic [WIDTH:0]   divisor_ext;
    logic [WIDTH:0]   divisor_mag;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH+1:0] a_sh;
    logic [WIDTH+1:0] trial;

    // Widening by one bit makes |most-negative| exact for the divisor;
    // the dividend magnitude fits WIDTH bits when read as unsigned.
    assign divisor_ext  = {divisor[WIDTH-1], divisor};
    assign divisor_mag  = divisor[WIDTH-1] ? -divisor_ext : divisor_ext;
    assign dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;

    assign a_sh  = {a, q[WIDTH-1]};
    assign trial = a_sh - {1'b0, m};

    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            a           <= '0;
            q           <= '0;
            m           <= '0;
            count       <= '0;
            qneg        <= 1'b0;
            rneg        <= 1'b0;
            ovf_case    <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            a        <= '0;
                            q        <= dividend_mag;
                            m        <= divisor_mag;
                            count    <= '0;
                            qneg     <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            rneg     <= dividend[WIDTH-1];
                            ovf_case <= (dividend == MOST_NEG) && (divisor == '1);
                            busy     <= 1'b1;
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    // A non-negative trial difference means the divisor fits.
                    if (!trial[WIDTH+1]) begin
                        a <= trial[WIDTH:0];
                        q <= {q[WIDTH-2:0], 1'b1};
                    end else begin
                        a <= a_sh[WIDTH:0];
                        q <= {q[WIDTH-2:0], 1'b0};
                    end
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    quotient    <= qneg ? -q : q;
                    remainder   <= rneg ? -a[WIDTH-1:0] : a[WIDTH-1:0];
                    div_by_zero <= 1'b0;
                    overflow    <= ovf_case;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
